// File: rtl/adder_result_acc.sv
// ---------------------------------------------------------------------------
// adder_result_acc
//
// Collects NUM_SAMPLES unsigned adder results (IN_W bits, zero-extended) into
// an ACC_W-bit accumulator. It then holds the total on a valid/ready output
// until the consumer takes it. An overflow flag records whether the true sum
// exceeded 2^ACC_W-1 while the result was being formed.
//
// Optional feature (compile-time macro ACC_SAT_EN):
//   defined     : on overflow the accumulator clamps to 2^ACC_W-1 and stays there
//   not defined : the accumulator wraps modulo 2^ACC_W
//   In both builds io_out_ovf is sticky until the result is consumed or cleared.
//
// Handshake rules (both sides):
//   A transfer happens on a rising clock edge where valid and ready are both 1.
//   Ready never depends on valid. Valid and the data stay stable until the
//   transfer happens.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   io_in_valid  in   io_in_sum is valid this cycle
//   io_in_ready  out  a sample is accepted this cycle: (state==ACC) & ~io_clear
//   io_in_sum    in   IN_W-bit unsigned adder result
//   io_clear     in   synchronous clear; drops any partial or pending result
//   io_out_valid out  a completed result is held (state==DONE)
//   io_out_ready in   the consumer accepts the result
//   io_out_acc   out  accumulated total (the accumulator register)
//   io_out_ovf   out  overflow occurred while forming this result
//   state_dbg    out  current FSM state (0 = ACC, 1 = DONE)
// ---------------------------------------------------------------------------
module adder_result_acc #(
    parameter int IN_W        = 9,
    parameter int ACC_W       = 16,
    parameter int NUM_SAMPLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [IN_W-1:0]  io_in_sum,
    input  logic             io_clear,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [ACC_W-1:0] io_out_acc,
    output logic             io_out_ovf,
    output logic             state_dbg
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(NUM_SAMPLES - 1);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [7:0]         cnt;
    logic               ovf;

    // One spare bit catches the carry out of the accumulator.
    logic [ACC_W:0]     next_sum;
    logic [ACC_W-1:0]   acc_upd;

    assign next_sum = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, io_in_sum};

`ifdef ACC_SAT_EN
    // Clamp to all-ones. Once acc is saturated, every later sample overflows
    // again, so acc stays at its maximum.
    assign acc_upd = next_sum[ACC_W] ? {ACC_W{1'b1}} : next_sum[ACC_W-1:0];
`else
    assign acc_upd = next_sum[ACC_W-1:0];
`endif

    assign io_in_ready  = (state == ST_ACC) & ~io_clear;
    assign io_out_valid = (state == ST_DONE);
    assign io_out_acc   = acc;
    assign io_out_ovf   = ovf;
    assign state_dbg    = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (io_clear) begin
            // Clear wins over everything, including a pending DONE result
            // that the consumer is accepting in the same cycle.
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    // io_clear is 0 on this branch, so in_ready is 1 and
                    // io_in_valid alone decides whether a sample fires.
                    if (io_in_valid) begin
                        acc <= acc_upd;
                        cnt <= cnt + 8'd1;
                        if (next_sum[ACC_W]) begin
                            ovf <= 1'b1;
                        end
                        if (cnt == LAST_CNT) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (io_out_ready) begin
                        state <= ST_ACC;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end

endmodule

// File: doc/adder_result_acc.md
Name: adder_result_acc

Overview:
- Downstream consumer of the 8-bit ripple-carry adder stage. Takes its 9-bit sum (8 sum bits plus carry) through a valid/ready handshake.
- Accumulates NUM_SAMPLES sums into a wider register, then presents the total on a valid/ready output.
- Reports accumulator overflow.
- Sits between the adder datapath and any block that needs block sums or averages.

Parameters:
- IN_W, 9, width of the incoming adder result (zero-extended, unsigned).
- ACC_W, 16, accumulator and output width; must be >= IN_W.
- NUM_SAMPLES, 4, sums per result; legal range 1..255.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_in_valid  input  1  io_in_sum is valid this cycle.
- io_in_ready  output  1  block accepts a sample this cycle.
- io_in_sum  input  IN_W  unsigned adder result.
- io_clear  input  1  synchronous clear: discards partial or pending result.
- io_out_valid  output  1  io_out_acc / io_out_ovf hold a completed result.
- io_out_ready  input  1  consumer accepts the result.
- io_out_acc  output  ACC_W  accumulated total.
- io_out_ovf  output  1  overflow occurred while forming this result.

Behaviour:
- State machine: ACC (collecting) and DONE (result held). Internal state: acc[ACC_W], cnt[8], ovf.
- Reset (reset=0, asynchronous): state=ACC, acc=0, cnt=0, ovf=0, io_out_valid=0.
  - io_in_ready is 1 from the first cycle after reset deassertion.
  - Reset mid-accumulation or mid-DONE drops all data; no partial result is emitted.
- io_in_ready = (state==ACC) & ~io_clear. Combinational, with no dependence on io_in_valid.
- io_out_valid = (state==DONE). io_out_acc = acc. io_out_ovf = ovf. All driven directly from registers.
- Input fire = io_in_valid & io_in_ready. On fire in ACC:
  - Compute next = acc + zero_extend(io_in_sum) at ACC_W+1 bits. acc <= next[ACC_W-1:0]. If next[ACC_W]=1, set ovf.
  - cnt <= cnt+1.
  - If cnt == NUM_SAMPLES-1, go to DONE; the accumulated sample is included in the result.
- No fire in ACC: state unchanged.
- DONE:
  - io_in_ready=0, so upstream is back-pressured.
  - acc and ovf are held stable while io_out_valid=1 and io_out_ready=0.
  - On io_out_ready=1: acc=0, cnt=0, ovf=0, state=ACC.
- Throughput: NUM_SAMPLES input cycles + at least 1 output cycle per result. Latency from last input fire to io_out_valid is 1 cycle.
- NUM_SAMPLES=1: every accepted sample goes straight to DONE. Output = that sample.
- io_clear=1 has top priority in any state. Next cycle: acc=0, cnt=0, ovf=0, state=ACC.
  - A sample presented in the clear cycle is not accepted (io_in_ready=0).
  - A pending DONE result is dropped even if io_out_ready=1.
- io_in_sum is ignored when no fire occurs. X on io_in_sum without io_in_valid must not corrupt state.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: on overflow (next[ACC_W]=1), acc clamps to 2^ACC_W-1 and ovf is set. Further samples keep acc at max.
- Not defined: acc wraps modulo 2^ACC_W and ovf is set (sticky until the result is consumed or cleared).
- Handshake, cnt and state behaviour are identical in both builds.

Test Plan:
- Basic: defaults, inputs 255, 510, 1, 4 with valid held high. io_out_valid rises the cycle after the 4th fire; io_out_acc=770, io_out_ovf=0. Consume with io_out_ready=1; io_in_ready returns 1 the next cycle.
- Back-pressure:
  - Complete a result, hold io_out_ready=0 for 5 cycles. io_out_acc stays stable, io_in_ready=0, extra io_in_valid pulses are ignored.
  - Raise io_out_ready; exactly one result is consumed.
- Overflow: ACC_W=10, NUM_SAMPLES=3, inputs 510, 510, 510.
  - Without ACC_SAT_EN: io_out_acc=506, io_out_ovf=1.
  - With ACC_SAT_EN: io_out_acc=1023, io_out_ovf=1.
- Clear:
  - After 2 of 4 samples (100, 200), pulse io_clear with io_in_valid=1, sum 7. Sample 7 is not accepted.
  - Then inputs 1, 2, 3, 4 give io_out_acc=10.
  - io_clear during DONE with io_out_ready=1 drops the result; io_out_valid=0 the next cycle.
- Async reset:
  - Assert reset=0 mid-cycle during accumulation. io_out_valid=0 and internal state clear immediately, without waiting for a clock edge.
  - After release, 4 samples of 1 give io_out_acc=4.
- NUM_SAMPLES=1: a stream of 9, 0, 511 with io_out_ready=1 produces results 9, 0, 511 at one result per 2 cycles.
